seq_serializer: RTL and testbench



---
 rtl/seq_serializer.sv | 209 ++++++++++++++++++++
 tb/tb_seq_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// -----------------------------------------------------------------------------
// seq_serializer
//
// Parallel-to-serial frame transmitter. A word accepted over a valid/ready
// handshake is sent as: start bit (0), data MSB first, optional even parity,
// stop bit (1). Each bit is held for DIV clock cycles.
//
// Optional feature macro: SER_PARITY_EN
//   defined   -> a PARITY bit period (XOR of the latched word) is inserted
//                between the last data bit and the stop bit.
//   undefined -> DATA goes straight to STOP; no parity state or logic exists.
//
// Parameters:
//   DATA_W  data word width in bits (2..16)
//   DIV     clock cycles per serial bit (1..255)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   din         parallel word, sampled only on the accept edge
//   din_valid   din holds a valid word
//   din_ready   block accepts a word this cycle (IDLE, after reset release)
//   sout        serial data out, idles high
//   bit_stb     strobe in the last cycle of every bit period
//   busy        frame in progress
//   frame_done  pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module seq_serializer #(
    parameter int DATA_W = 8,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              bit_stb,
    output logic              busy,
    output logic              frame_done
);

    // Divider counter is at least one bit wide so DIV=1 still has a legal vector.
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_shift;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_rdy_en;    // holds din_ready low until the first edge after reset
`ifdef SER_PARITY_EN
    logic              r_parity;
`endif

    logic              w_div_last;
    logic              w_accept;

    assign w_div_last = (r_div_cnt == DIV_LAST);
    assign w_accept   = (r_state == S_IDLE) && r_rdy_en && din_valid;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs. Outputs decode only registered state, so there
    // is no combinational path from din/din_valid to any output.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        w_state_nxt = r_state;
        din_ready   = 1'b0;
        sout        = 1'b1;
        busy        = 1'b1;
        bit_stb     = 1'b0;
        frame_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                din_ready = r_rdy_en;
                if (w_accept) begin
                    w_state_nxt = S_START;
                end
            end

            S_START: begin
                sout    = 1'b0;
                bit_stb = w_div_last;
                if (w_div_last) begin
                    w_state_nxt = S_DATA;
                end
            end

            S_DATA: begin
                sout    = r_shift[DATA_W-1];
                bit_stb = w_div_last;
                if (w_div_last && (r_bit_cnt == BIT_LAST)) begin
`ifdef SER_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end
            end

`ifdef SER_PARITY_EN
            S_PARITY: begin
                sout    = r_parity;
                bit_stb = w_div_last;
                if (w_div_last) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif

            S_STOP: begin
                sout       = 1'b1;
                bit_stb    = w_div_last;
                frame_done = w_div_last;
                if (w_div_last) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: shift register, divider, bit counter, ready enable.
    // -------------------------------------------------------------------------
    // NOTE: the shift register is reset even though its contents are only used
    // after an accept; it is a handful of flops, and a known value keeps
    // post-reset behaviour deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_rdy_en  <= 1'b0;
`ifdef SER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_rdy_en <= 1'b1;

            if (w_accept) begin
                r_shift <= din;
`ifdef SER_PARITY_EN
                r_parity <= ^din;
`endif
            end else if ((r_state == S_DATA) && w_div_last) begin
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            end

            // Non-IDLE states only change on a divider wrap, so clearing on
            // the wrap also clears the counter on every state transition.
            if ((r_state == S_IDLE) || w_div_last) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end

            if (r_state != S_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_div_last) begin
                r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// -----------------------------------------------------------------------------
// tb_seq_serializer
//
// Directed bench for seq_serializer. Two instances share clk/rst_n: one with
// DIV=1 and one with DIV=4 (both DATA_W=8). Expected serial frames are built
// from the word by the bench: {start 0, data MSB first, [even parity], stop 1}.
// Honours SER_PARITY_EN to match the RTL build.
// -----------------------------------------------------------------------------
module tb_seq_serializer;

    logic       clk;
    logic       rst_n;

    logic [7:0] din_1;
    logic       din_valid_1;
    logic       din_ready_1, sout_1, bit_stb_1, busy_1, frame_done_1;

    logic [7:0] din_4;
    logic       din_valid_4;
    logic       din_ready_4, sout_4, bit_stb_4, busy_4, frame_done_4;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

`ifdef SER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    seq_serializer #(.DATA_W(8), .DIV(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_1),
        .din_valid  (din_valid_1),
        .din_ready  (din_ready_1),
        .sout       (sout_1),
        .bit_stb    (bit_stb_1),
        .busy       (busy_1),
        .frame_done (frame_done_1)
    );

    seq_serializer #(.DATA_W(8), .DIV(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din_4),
        .din_valid  (din_valid_4),
        .din_ready  (din_ready_4),
        .sout       (sout_4),
        .bit_stb    (bit_stb_4),
        .busy       (busy_4),
        .frame_done (frame_done_4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int sel, input logic [7:0] d, input logic v);
        if (sel == 0) begin
            din_1       = d;
            din_valid_1 = v;
        end else begin
            din_4       = d;
            din_valid_4 = v;
        end
    endtask

    // Selected-instance output snapshot: {ready, sout, stb, busy, done}
    function automatic logic [4:0] outs(input int sel);
        if (sel == 0) return {din_ready_1, sout_1, bit_stb_1, busy_1, frame_done_1};
        return {din_ready_4, sout_4, bit_stb_4, busy_4, frame_done_4};
    endfunction

    // Called at a negedge with the instance idle. Presents w, checks the whole
    // frame cycle by cycle, returns at the negedge of the mandatory idle cycle.
    task automatic tx_frame(input int sel, input string tag, input logic [7:0] w,
                            input bit keep_valid, output int t_start);
        int         div;
        logic [10:0] fr;
        logic [4:0] o;
        div = (sel == 0) ? 1 : 4;
`ifdef SER_PARITY_EN
        fr = {1'b0, w, ^w, 1'b1};
`else
        fr = {1'b0, 1'b0, w, 1'b1};
`endif
        set_in(sel, w, 1'b1);
        o = outs(sel);
        check({tag, " ready before accept"}, o[4], 1'b1);
        @(negedge clk);
        t_start = cyc;
        // din is only sampled on the accept edge; scramble it afterwards
        set_in(sel, ~w, keep_valid);
        for (int b = 0; b < NB; b++) begin
            for (int c = 0; c < div; c++) begin
                o = outs(sel);
                check($sformatf("%s b%0d c%0d sout", tag, b, c), o[3], fr[NB-1-b]);
                check($sformatf("%s b%0d c%0d bit_stb", tag, b, c), o[2], (c == div - 1));
                check($sformatf("%s b%0d c%0d busy/ready", tag, b, c), {o[1], o[4]}, 2'b10);
                check($sformatf("%s b%0d c%0d frame_done", tag, b, c), o[0],
                      (b == NB - 1) && (c == div - 1));
                @(negedge clk);
            end
        end
        o = outs(sel);
        check({tag, " idle {ready,sout,stb,busy,done}"}, o, 5'b11000);
    endtask

    initial begin
        int t0, t1;
        logic [4:0] o;

        rst_n = 1'b0;
        set_in(0, 8'hA5, 1'b1);
        set_in(1, 8'hA5, 1'b1);

        // Reset held 50 ns with din_valid high
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d dut1 outs", i), outs(0), 5'b01000);
            check($sformatf("rst%0d dut4 outs", i), outs(1), 5'b01000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release ready still low", {din_ready_1, din_ready_4}, 2'b00);
        @(negedge clk);
        check("one cycle after release ready", {din_ready_1, din_ready_4}, 2'b11);
        check("no accept while not ready", {busy_1, busy_4}, 2'b00);
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);
        @(negedge clk);

        // Single frame, DIV=1
        tx_frame(0, "A5 div1", 8'hA5, 1'b0, t0);

        // DIV=4 frame
        tx_frame(1, "0F div4", 8'h0F, 1'b0, t0);

        // Back-to-back with din_valid held high
        tx_frame(0, "b2b 0F", 8'h0F, 1'b1, t0);
        tx_frame(0, "b2b F0", 8'hF0, 1'b0, t1);
        check("b2b start spacing", t1 - t0, NB + 1);

        // Odd-parity word (parity bit 1 when enabled)
        tx_frame(0, "07 div1", 8'h07, 1'b0, t0);

        // Reset during DATA bit 3 of A5 (that bit is 0)
        set_in(0, 8'hA5, 1'b1);
        @(negedge clk);
        set_in(0, 8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        check("midrst pre sout/busy", {sout_1, busy_1}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("midrst async outs", outs(0), 5'b01000);
        @(negedge clk);
        check("midrst held outs", outs(0), 5'b01000);
        rst_n = 1'b1;
        @(negedge clk);
        o = outs(0);
        check("midrst ready after release", o, 5'b11000);
        tx_frame(0, "3C after rst", 8'h3C, 1'b0, t0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
